// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I core slice: the instruction loader
// state encoding, the default frame start marker, and base opcode values.
package rv32i_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } loader_state_e;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_REG    = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/inst_loader.sv
// Instruction loader: receives a framed byte stream (sync, word count,
// little-endian words, XOR checksum) and writes each assembled word into
// the instruction RAM, holding the core in reset until a frame checks out.
// The count field is one byte, so DEPTH is meaningful only up to 255.
module inst_loader
  import rv32i_pkg::*;
#(
  parameter int         DEPTH     = 64,
  parameter logic [7:0] SYNC_BYTE = LOADER_SYNC_BYTE
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [7:0]  iRxData,
  input  logic        iRxValid,
  output logic        oWrEn,
  output logic [31:0] oWrAddr,
  output logic [31:0] oWrData,
  output logic        oCpuRst,
  output logic        oBusy,
  output logic        oDone,
  output logic        oErr
);

  loader_state_e state;
  loader_state_e state_next;

  logic [7:0]  word_idx;
  logic [7:0]  word_cnt;
  logic [7:0]  checksum;
  logic [1:0]  byte_idx;
  logic [31:0] asm_word;
  logic [31:0] asm_next;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_rst;

  logic is_sync;
  logic count_ok;
  logic last_word;

  assign is_sync   = iRxValid && (iRxData == SYNC_BYTE);
  assign count_ok  = (iRxData != 8'd0) && ({24'd0, iRxData} <= DEPTH[31:0]);
  assign last_word = (word_idx == (word_cnt - 8'd1));

  // Drop the incoming byte into its lane of the assembly word; the write
  // register takes this combined value so the 4th byte needs no extra cycle.
  always_comb begin
    asm_next = asm_word;
    case (byte_idx)
      2'd0:    asm_next[7:0]   = iRxData;
      2'd1:    asm_next[15:8]  = iRxData;
      2'd2:    asm_next[23:16] = iRxData;
      default: asm_next[31:24] = iRxData;
    endcase
  end

  // Next-state decode; no byte strobe means no movement in any state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERROR: begin
        if (is_sync) state_next = COUNT;
      end
      COUNT: begin
        if (iRxValid) state_next = count_ok ? DATA : ERROR;
      end
      DATA: begin
        if (iRxValid && (byte_idx == 2'd3) && last_word) state_next = CHECK;
      end
      CHECK: begin
        if (iRxValid) state_next = (iRxData == checksum) ? DONE : ERROR;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= state_next;
  end

  // Counters, checksum, assembly word and the separately registered write port.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      word_idx <= 8'd0;
      word_cnt <= 8'd0;
      checksum <= 8'd0;
      byte_idx <= 2'd0;
      asm_word <= 32'd0;
      wr_en    <= 1'b0;
      wr_addr  <= 32'd0;
      wr_data  <= 32'd0;
      cpu_rst  <= 1'b1;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (is_sync) begin
            word_idx <= 8'd0;
            byte_idx <= 2'd0;
            checksum <= 8'd0;
            cpu_rst  <= 1'b1;
          end
        end
        COUNT: begin
          if (iRxValid && count_ok) word_cnt <= iRxData;
        end
        DATA: begin
          if (iRxValid) begin
            asm_word <= asm_next;
            checksum <= checksum ^ iRxData;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              wr_en    <= 1'b1;
              wr_addr  <= {22'd0, word_idx, 2'b00};
              wr_data  <= asm_next;
              word_idx <= word_idx + 8'd1;
            end
          end
        end
        CHECK: begin
          if (iRxValid && (iRxData == checksum)) cpu_rst <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign oWrEn   = wr_en;
  assign oWrAddr = wr_addr;
  assign oWrData = wr_data;
  assign oCpuRst = cpu_rst;
  assign oBusy   = (state == COUNT) || (state == DATA) || (state == CHECK);
  assign oDone   = (state == DONE);
  assign oErr    = (state == ERROR);

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: drives framed byte streams and checks the
// logged RAM writes and status outputs against hand-computed expectations.
module tb_inst_loader;

  localparam int DEPTH   = 64;
  localparam int LOGSIZE = 512;

  logic        iClk = 1'b0;
  logic        iRst = 1'b0;
  logic [7:0]  iRxData = 8'd0;
  logic        iRxValid = 1'b0;
  logic        oWrEn;
  logic [31:0] oWrAddr;
  logic [31:0] oWrData;
  logic        oCpuRst;
  logic        oBusy;
  logic        oDone;
  logic        oErr;

  int compareCount  = 0;
  int mismatchCount = 0;

  int cycle      = 0;
  int lastAccept = 0;
  int bytesSent  = 0;
  int frameBase  = 0;
  int frameBytes = 0;

  logic [31:0] logAddr  [LOGSIZE];
  logic [31:0] logData  [LOGSIZE];
  int          logDelta [LOGSIZE];
  int          logBytes [LOGSIZE];
  int          writeCount = 0;

  logic [31:0] frameWords [DEPTH];

  inst_loader #(.DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iRxData (iRxData),
    .iRxValid(iRxValid),
    .oWrEn   (oWrEn),
    .oWrAddr (oWrAddr),
    .oWrData (oWrData),
    .oCpuRst (oCpuRst),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oErr    (oErr)
  );

  // Free-running clock and a cycle counter for write latency measurement.
  always #5 iClk = ~iClk;

  always @(posedge iClk) cycle <= cycle + 1;

  // Log every write strobe with its address, data, latency from the last
  // accepted byte, and how many bytes had been sent when it appeared.
  always @(negedge iClk) begin
    if (oWrEn) begin
      if (writeCount < LOGSIZE) begin
        logAddr[writeCount]  = oWrAddr;
        logData[writeCount]  = oWrData;
        logDelta[writeCount] = cycle - lastAccept;
        logBytes[writeCount] = bytesSent;
      end
      writeCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge iClk);
    iRxValid = 1'b1;
    iRxData  = b;
    @(posedge iClk);
    #1;
    lastAccept = cycle;
    bytesSent++;
    @(negedge iClk);
    iRxValid = 1'b0;
  endtask

  task automatic pickGap(input int gapMax, output int gap);
    if (gapMax == 0) gap = 0;
    else             gap = int'($urandom_range(0, gapMax));
  endtask

  task automatic sendFrame(input int n, input int gapMax, input logic badSum);
    logic [7:0]  sum;
    logic [7:0]  b;
    logic [31:0] w;
    int          gap;
    sum        = 8'd0;
    frameBase  = writeCount;
    frameBytes = bytesSent;
    pickGap(gapMax, gap);
    applyStimulus(8'hA5, gap);
    pickGap(gapMax, gap);
    applyStimulus(n[7:0], gap);
    for (int i = 0; i < n; i++) begin
      w = frameWords[i];
      for (int k = 0; k < 4; k++) begin
        b   = w[8*k +: 8];
        sum = sum ^ b;
        pickGap(gapMax, gap);
        applyStimulus(b, gap);
      end
    end
    pickGap(gapMax, gap);
    applyStimulus(badSum ? (sum ^ 8'hFF) : sum, gap);
  endtask

  task automatic checkWrites(input string tag, input int n);
    checkOutput($sformatf("%s_count", tag), writeCount - frameBase, n);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), logAddr[frameBase+i], 32'(i * 4));
      checkOutput($sformatf("%s_data%0d", tag, i), logData[frameBase+i], frameWords[i]);
      checkOutput($sformatf("%s_lat%0d", tag, i), logDelta[frameBase+i], 0);
      checkOutput($sformatf("%s_pos%0d", tag, i), logBytes[frameBase+i],
                  frameBytes + 2 + 4 * (i + 1));
    end
  endtask

  task automatic checkStatus(input string tag, input logic cpuRst, input logic busy,
                             input logic done, input logic err);
    checkOutput({tag, "_cpurst"}, oCpuRst, cpuRst);
    checkOutput({tag, "_busy"}, oBusy, busy);
    checkOutput({tag, "_done"}, oDone, done);
    checkOutput({tag, "_err"}, oErr, err);
  endtask

  task automatic doReset();
    @(negedge iClk);
    iRst     = 1'b1;
    iRxValid = 1'b0;
    @(negedge iClk);
    iRst = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkStatus(tag, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_wren"}, oWrEn, 1'b0);
    checkOutput({tag, "_addr"}, oWrAddr, 32'd0);
    checkOutput({tag, "_data"}, oWrData, 32'd0);
  endtask

  initial begin
    doReset();
    checkReset("reset");

    // Junk in IDLE is ignored.
    applyStimulus(8'h33, 0);
    checkStatus("idlejunk", 1'b1, 1'b0, 1'b0, 1'b0);

    // Single word frame, checksum 33^01^21^00 = 13.
    frameWords[0] = 32'h00210133;
    sendFrame(1, 0, 1'b0);
    checkWrites("one", 1);
    checkStatus("one", 1'b0, 1'b0, 1'b1, 1'b0);

    // Two words back-to-back; the second carries sync values as data.
    frameWords[0] = 32'h11223344;
    frameWords[1] = 32'hA500A57F;
    sendFrame(2, 0, 1'b0);
    checkWrites("two", 2);
    checkStatus("two", 1'b0, 1'b0, 1'b1, 1'b0);

    // Wrong checksum: the word stays written, loader flags error.
    frameWords[0] = 32'hCAFEF00D;
    sendFrame(1, 0, 1'b1);
    checkWrites("badsum", 1);
    checkStatus("badsum", 1'b1, 1'b0, 1'b0, 1'b1);
    frameWords[0] = 32'h0000006F;
    sendFrame(1, 0, 1'b0);
    checkWrites("recover", 1);
    checkStatus("recover", 1'b0, 1'b0, 1'b1, 1'b0);

    // Count of zero and count above DEPTH both fail without writes.
    frameBase = writeCount;
    applyStimulus(8'hA5, 0);
    checkStatus("cnt0_count", 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 0);
    checkStatus("cnt0", 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h41, 0);
    repeat (2) @(negedge iClk);
    checkStatus("cnt65", 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("badcnt_writes", writeCount - frameBase, 0);

    // Reset after the second data byte discards the frame.
    frameBase = writeCount;
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    doReset();
    checkReset("midreset");
    frameWords[0] = 32'h00500093;
    sendFrame(1, 0, 1'b0);
    checkWrites("afterreset", 1);
    checkStatus("afterreset", 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset on the same edge as a 4th data byte suppresses the write.
    frameBase = writeCount;
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h03, 0);
    iRst     = 1'b1;
    iRxValid = 1'b1;
    iRxData  = 8'h04;
    @(negedge iClk);
    iRst     = 1'b0;
    iRxValid = 1'b0;
    checkReset("rst4th");
    repeat (2) @(negedge iClk);
    checkOutput("rst4th_writes", writeCount - frameBase, 0);

    // Full-depth frame, back-to-back then with random gaps.
    for (int i = 0; i < DEPTH; i++)
      frameWords[i] = {8'(i), 8'(i + 1), 8'(i * 3), 8'(~i)};
    sendFrame(DEPTH, 0, 1'b0);
    checkWrites("full", DEPTH);
    checkOutput("full_lastaddr", logAddr[frameBase+DEPTH-1], 32'hFC);
    checkStatus("full", 1'b0, 1'b0, 1'b1, 1'b0);
    sendFrame(DEPTH, 3, 1'b0);
    checkWrites("fullgap", DEPTH);
    checkOutput("fullgap_lastaddr", logAddr[frameBase+DEPTH-1], 32'hFC);
    checkStatus("fullgap", 1'b0, 1'b0, 1'b1, 1'b0);

    repeat (3) @(negedge iClk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter DEPTH, default 64, is the instruction memory depth in 32-bit words.
REQ-002 Parameter SYNC_BYTE, default 8'hA5, is the frame start marker.
REQ-003 iClk  input  1  system clock; all state changes on rising edge.
REQ-004 iRst  input  1  reset, synchronous, active-high.
REQ-005 iRxData  input  8  incoming byte from the byte-stream receiver.
REQ-006 iRxValid  input  1  single-cycle strobe; iRxData is valid while this is high.
REQ-007 oWrEn  output  1  one-cycle instruction-memory write strobe.
REQ-008 oWrAddr  output  32  byte address of the write; always word aligned, bits [1:0]=0.
REQ-009 oWrData  output  32  instruction word to write.
REQ-010 oCpuRst  output  1  holds the core in reset while a program is absent or loading.
REQ-011 oBusy  output  1  high while a frame is in progress (states COUNT, DATA, CHECK).
REQ-012 oDone  output  1  high in state DONE.
REQ-013 oErr  output  1  high in state ERROR.

Function
REQ-014 Frame format: SYNC_BYTE, word count N (1 byte), 4*N data bytes with each word little-endian (first byte = bits [7:0]), then XOR checksum of all 4*N data bytes.
REQ-015 FSM states: IDLE, COUNT, DATA, CHECK, DONE, ERROR; one state register, next state is combinational.
REQ-016 IDLE/DONE/ERROR: a strobed byte equal to SYNC_BYTE moves to COUNT, clears the word index, byte index and checksum, and sets oCpuRst=1; other bytes are ignored.
REQ-017 COUNT: a strobed N with 1<=N<=DEPTH latches N and moves to DATA; N=0 or N>DEPTH moves to ERROR.
REQ-018 DATA: each strobed byte shifts into a 32-bit assembly register at lane byte index [1:0], XORs into the checksum, and increments the byte index modulo 4.
REQ-019 On acceptance of byte index 3, the next cycle SHALL present oWrEn=1 for exactly one cycle, with oWrAddr={word index,2'b00} and oWrData equal to the assembled word; the word index then increments.
REQ-020 Write data and address SHALL be registered separately from the assembly register, so that back-to-back iRxValid on every cycle loses no byte.
REQ-021 After the Nth word's 4th byte, DATA moves to CHECK.
REQ-022 CHECK: a strobed byte equal to the running checksum moves to DONE and clears oCpuRst; a mismatch moves to ERROR with oCpuRst held at 1.
REQ-023 Words already written before an ERROR are not rolled back.
REQ-024 iRxValid low in any state causes no state change; there is no timeout.
REQ-025 oWrEn SHALL never assert outside the cycle defined in REQ-019, and oWrAddr SHALL never exceed (DEPTH-1)*4.
REQ-026 A SYNC_BYTE value received inside COUNT, DATA or CHECK is treated as ordinary data, not as a restart.

Reset
REQ-027 iRst=1 at a clock edge forces IDLE, oCpuRst=1, oWrEn=0, oWrAddr=0, oWrData=0, oBusy=0, oDone=0, oErr=0, and clears all counters and the checksum.
REQ-028 Reset asserted mid-frame discards the frame; no oWrEn pulse SHALL occur in the cycle after reset, even if a word was just completed.

Structure
REQ-029 The state enum, the SYNC_BYTE default and the 7-bit opcode constants SHALL live in a shared package, rv32i_pkg, that the core modules also import.
REQ-030 The block is a single module with no sub-modules; the instruction ROM is replaced by a RAM that provides a write port and is driven by oWrEn, oWrAddr and oWrData.

Verification
REQ-031 Stream A5,01,33,01,21,00,checksum 13 -> one oWrEn with oWrAddr=0 and oWrData=32'h00210133; then oDone=1, oCpuRst=0.
REQ-032 Stream A5,02, 8 bytes sent back-to-back, correct checksum -> writes at addresses 0 and 4, one cycle after each 4th byte.
REQ-033 Stream A5,01,4 data bytes, wrong checksum -> word written, then oErr=1, oCpuRst=1; a fresh valid frame then reaches DONE.
REQ-034 Stream A5,00 -> ERROR; stream A5,41 with DEPTH=64 -> ERROR; no oWrEn in either case.
REQ-035 iRst pulsed after the 2nd data byte -> all outputs at reset values, no write; the next full frame loads correctly.
REQ-036 Frame with N=64 -> last write at oWrAddr=32'hFC; random gaps on iRxValid give identical results.
